// File: rtl/rescale_pkg.sv
// rescale_pkg: shared types and helpers for the rescale line fetch block.
//   rgb565_t       16-bit packed pixel {R[4:0], G[5:0], B[4:0]}
//   fetch_state_e  line-fetch FSM states
//   SRC_W_DEF      default source stamp width in pixels
//   rgb888_to_565  converts a {8'h00, R, G, B} stream word to RGB565
package rescale_pkg;

  localparam int SRC_W_DEF = 8;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'd0,
    FS_DISCARD  = 3'd1,
    FS_LOAD_TOP = 3'd2,
    FS_LOAD_BOT = 3'd3,
    FS_READY    = 3'd4
  } fetch_state_e;

  // Truncates each channel to its top bits; the pad byte is dropped.
  function automatic rgb565_t rgb888_to_565(input logic [31:0] d);
    return {d[23:19], d[15:10], d[7:3]};
  endfunction

endpackage

// File: rtl/rescale_line_mem.sv
// rescale_line_mem: two SRC_W x 16-bit register lines (top, bottom).
//   clk_i, rst_ni          clock, synchronous active-low reset (clears both lines)
//   wr_en_i, wr_bot_i      write strobe and line select (0 = top, 1 = bottom)
//   wr_col_i, wr_data_i    write column and RGB565 pixel
//   copy_i                 parallel copy of the bottom line into the top line
//   offset_i               left-neighbour column, two's complement
//   top0_o/top1_o          top[col] / top[col1]
//   bot0_o/bot1_o          bottom[col] / bottom[col1]
// col is offset_i clamped to [0, SRC_W-1]; col1 = min(col+1, SRC_W-1).
module rescale_line_mem import rescale_pkg::*; #(
  parameter int SRC_W = SRC_W_DEF,
  parameter int OFS_W = 11
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic                       wr_bot_i,
  input  logic [$clog2(SRC_W)-1:0]   wr_col_i,
  input  rgb565_t                    wr_data_i,
  input  logic                       copy_i,
  input  logic [OFS_W-1:0]           offset_i,
  output rgb565_t                    top0_o,
  output rgb565_t                    top1_o,
  output rgb565_t                    bot0_o,
  output rgb565_t                    bot1_o
);

  localparam int CW = $clog2(SRC_W);
  localparam logic [CW-1:0] LAST_COL = CW'(SRC_W - 1);

  rgb565_t top_q [SRC_W];
  rgb565_t bot_q [SRC_W];

  logic [CW-1:0] col0;
  logic [CW-1:0] col1;

  // Negative offsets pin to column 0; anything at or past the last column
  // pins there, so the right neighbour replicates the edge pixel.
  always_comb begin
    col0 = '0;
    if (offset_i[OFS_W-1]) begin
      col0 = '0;
    end else if (32'(offset_i) >= 32'(SRC_W - 1)) begin
      col0 = LAST_COL;
    end else begin
      col0 = offset_i[CW-1:0];
    end
    col1 = (col0 == LAST_COL) ? LAST_COL : col0 + 1'b1;
  end

  // Copy and write never coincide: copy happens on a request cycle, when
  // the fetch FSM is not accepting beats.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SRC_W; i++) begin
        top_q[i] <= '0;
        bot_q[i] <= '0;
      end
    end else begin
      if (copy_i) begin
        for (int i = 0; i < SRC_W; i++) begin
          top_q[i] <= bot_q[i];
        end
      end
      if (wr_en_i) begin
        if (wr_bot_i) begin
          bot_q[wr_col_i] <= wr_data_i;
        end else begin
          top_q[wr_col_i] <= wr_data_i;
        end
      end
    end
  end

  assign top0_o = top_q[col0];
  assign top1_o = top_q[col1];
  assign bot0_o = bot_q[col0];
  assign bot1_o = bot_q[col1];

endmodule

// File: rtl/rescale_line_fetch.sv
// rescale_line_fetch: accepts RGB888 source rows over AXI4-Stream, stores two
// consecutive rows as RGB565 and serves the four bilinear neighbours.
//   clock, reset_n          clock, synchronous active-low reset
//   s_axis_tdata/tvalid/    source beats {8'h00, R, G, B}; tlast marks row end
//   tlast/tready
//   in_stream_ready         fetch request level; its rising edge is the request
//   reload                  1 = fresh window (skip row_to_wait rows first),
//                           0 = advance one row (bottom moves to top)
//   row_to_wait             rows to discard before a reload fetch
//   neighbor_offset         left-neighbour column, two's complement
//   neighbor0..3            registered top[col], top[col+1], bot[col], bot[col+1]
//   fetch_done              one-cycle pulse when the window becomes ready
//   window_valid            both lines valid and no fetch in progress
//   err                     sticky row-framing error
// Optional feature macro: RESCALE_TLAST_CHECK_EN enables the tlast framing
// check driving err; without it tlast is ignored and err is 0.
//
// Handshake: a beat transfers on a rising clock edge where s_axis_tvalid and
// s_axis_tready are both high. tready depends only on the FSM state (never on
// tvalid), and a beat with tvalid low leaves every counter untouched.
module rescale_line_fetch import rescale_pkg::*; #(
  parameter int SRC_W  = SRC_W_DEF,
  parameter int OFS_W  = 11,
  parameter int WAIT_W = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              in_stream_ready,
  input  logic              reload,
  input  logic [WAIT_W-1:0] row_to_wait,
  input  logic [OFS_W-1:0]  neighbor_offset,
  output logic [15:0]       neighbor0,
  output logic [15:0]       neighbor1,
  output logic [15:0]       neighbor2,
  output logic [15:0]       neighbor3,
  output logic              fetch_done,
  output logic              window_valid,
  output logic              err
);

  localparam int CW = $clog2(SRC_W);
  localparam logic [CW-1:0] LAST_COL = CW'(SRC_W - 1);

  fetch_state_e      state_q, state_d;
  logic              primed_q, primed_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CW-1:0]     col_q, col_d;
  logic              req_prev_q;
  logic              fetch_done_q, fetch_done_d;
  rgb565_t           nb0_q, nb1_q, nb2_q, nb3_q;

  logic    req, beat, row_end;
  logic    wr_en, wr_bot, copy;
  rgb565_t rd_top0, rd_top1, rd_bot0, rd_bot1;

  assign s_axis_tready = (state_q == FS_DISCARD) || (state_q == FS_LOAD_TOP) ||
                         (state_q == FS_LOAD_BOT);
  assign beat    = s_axis_tvalid & s_axis_tready;
  assign row_end = beat && (col_q == LAST_COL);
  assign req     = in_stream_ready & ~req_prev_q;

  always_comb begin
    state_d      = state_q;
    primed_d     = primed_q;
    wait_d       = wait_q;
    col_d        = col_q;
    fetch_done_d = 1'b0;
    wr_en        = 1'b0;
    wr_bot       = 1'b0;
    copy         = 1'b0;

    if (beat) begin
      col_d = row_end ? '0 : col_q + 1'b1;
    end

    case (state_q)
      FS_IDLE, FS_READY: begin
        if (req) begin
          col_d = '0;
          if (reload || !primed_q) begin
            wait_d  = row_to_wait;
            state_d = (row_to_wait != '0) ? FS_DISCARD : FS_LOAD_TOP;
          end else begin
            copy    = 1'b1;
            state_d = FS_LOAD_BOT;
          end
        end
      end
      FS_DISCARD: begin
        // wait_q is never zero here: a zero wait goes straight to LOAD_TOP.
        if (row_end) begin
          wait_d = wait_q - 1'b1;
          if (wait_q == WAIT_W'(1)) begin
            state_d = FS_LOAD_TOP;
          end
        end
      end
      FS_LOAD_TOP: begin
        wr_en = beat;
        if (row_end) begin
          state_d = FS_LOAD_BOT;
        end
      end
      FS_LOAD_BOT: begin
        wr_en  = beat;
        wr_bot = 1'b1;
        if (row_end) begin
          primed_d     = 1'b1;
          fetch_done_d = 1'b1;
          state_d      = FS_READY;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= FS_IDLE;
      primed_q     <= 1'b0;
      wait_q       <= '0;
      col_q        <= '0;
      req_prev_q   <= 1'b0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      primed_q     <= primed_d;
      wait_q       <= wait_d;
      col_q        <= col_d;
      req_prev_q   <= in_stream_ready;
      fetch_done_q <= fetch_done_d;
    end
  end

  rescale_line_mem #(
    .SRC_W (SRC_W),
    .OFS_W (OFS_W)
  ) u_mem (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .wr_en_i   (wr_en),
    .wr_bot_i  (wr_bot),
    .wr_col_i  (col_q),
    .wr_data_i (rgb888_to_565(s_axis_tdata)),
    .copy_i    (copy),
    .offset_i  (neighbor_offset),
    .top0_o    (rd_top0),
    .top1_o    (rd_top1),
    .bot0_o    (rd_bot0),
    .bot1_o    (rd_bot1)
  );

  // Neighbours follow the buffers every cycle, whether or not the window is valid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      nb0_q <= '0;
      nb1_q <= '0;
      nb2_q <= '0;
      nb3_q <= '0;
    end else begin
      nb0_q <= rd_top0;
      nb1_q <= rd_top1;
      nb2_q <= rd_bot0;
      nb3_q <= rd_bot1;
    end
  end

  assign neighbor0    = nb0_q;
  assign neighbor1    = nb1_q;
  assign neighbor2    = nb2_q;
  assign neighbor3    = nb3_q;
  assign fetch_done   = fetch_done_q;
  assign window_valid = primed_q & (state_q == FS_READY);

`ifdef RESCALE_TLAST_CHECK_EN
  // Framing keeps following col_q after a mismatch; err only records it.
  logic err_q;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (beat && (s_axis_tlast != (col_q == LAST_COL))) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rescale_line_fetch.sv
// tb_rescale_line_fetch: self-checking bench for rescale_line_fetch.
// The model keeps the expected window as two integer lines computed from the
// rows sent (reload: rows wait and wait+1 of the burst; advance: old bottom
// becomes top, new row becomes bottom) and clamps offsets arithmetically.
module tb_rescale_line_fetch;

  localparam int SRC_W  = 8;
  localparam int OFS_W  = 11;
  localparam int WAIT_W = 9;
`ifdef RESCALE_TLAST_CHECK_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  logic              clock;
  logic              reset_n;
  logic [31:0]       s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              in_stream_ready;
  logic              reload;
  logic [WAIT_W-1:0] row_to_wait;
  logic [OFS_W-1:0]  neighbor_offset;
  logic [15:0]       neighbor0, neighbor1, neighbor2, neighbor3;
  logic              fetch_done;
  logic              window_valid;
  logic              err;

  rescale_line_fetch #(
    .SRC_W  (SRC_W),
    .OFS_W  (OFS_W),
    .WAIT_W (WAIT_W)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .in_stream_ready (in_stream_ready),
    .reload          (reload),
    .row_to_wait     (row_to_wait),
    .neighbor_offset (neighbor_offset),
    .neighbor0       (neighbor0),
    .neighbor1       (neighbor1),
    .neighbor2       (neighbor2),
    .neighbor3       (neighbor3),
    .fetch_done      (fetch_done),
    .window_valid    (window_valid),
    .err             (err)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters / monitors ----------------
  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int fd_cnt   = 0;

  always @(negedge clock) begin
    if (s_axis_tvalid && s_axis_tready) acc_cnt++;
    if (fetch_done) fd_cnt++;
  end

  // ---------------- reference model ----------------
  int          top_m [SRC_W];
  int          bot_m [SRC_W];
  bit          primed_m;
  bit          err_m;
  logic [23:0] burst [0:7][0:SRC_W-1];

  typedef struct {
    logic [OFS_W-1:0] ofs;
    int               c0;
    int               c1;
  } vec_t;
  vec_t vt [9];

  function automatic int to565(input logic [23:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    return (r / 8) * 2048 + (g / 4) * 32 + (b / 8);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SRC_W; i++) begin
      top_m[i] = 0;
      bot_m[i] = 0;
    end
    primed_m = 1'b0;
    err_m    = 1'b0;
  endtask

  task automatic chk_cols(input logic [OFS_W-1:0] ofs, input int c0, input int c1);
    neighbor_offset = ofs;
    tick();
    tick();
    chk($sformatf("n0 ofs=%0h", ofs), int'(neighbor0), top_m[c0]);
    chk($sformatf("n1 ofs=%0h", ofs), int'(neighbor1), top_m[c1]);
    chk($sformatf("n2 ofs=%0h", ofs), int'(neighbor2), bot_m[c0]);
    chk($sformatf("n3 ofs=%0h", ofs), int'(neighbor3), bot_m[c1]);
  endtask

  task automatic chk_ofs(input logic [OFS_W-1:0] ofs);
    int o, c0, c1;
    o  = ofs[OFS_W-1] ? -1 : int'(ofs);
    c0 = (o < 0) ? 0 : ((o > SRC_W - 1) ? SRC_W - 1 : o);
    c1 = (c0 + 1 > SRC_W - 1) ? SRC_W - 1 : c0 + 1;
    chk_cols(ofs, c0, c1);
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [23:0] px, input bit last, input bit bubble);
    int g;
    if (bubble) begin
      s_axis_tvalid = 1'b0;
      tick();
    end
    s_axis_tdata  = {8'h00, px};
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    g = 0;
    while (!s_axis_tready && g < 40) begin
      tick();
      g++;
    end
    if (g >= 40) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual_tready=0 expected_tready=1");
    end
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic raise_request(input bit rl, input int w);
    in_stream_ready = 1'b0;
    tick();
    reload          = rl;
    row_to_wait     = WAIT_W'(w);
    in_stream_ready = 1'b1;
    tick();
  endtask

  // One complete fetch. abuse_idx: beat index before which a spurious request
  // edge is raised (-1 = none). bad_last_idx: beat whose tlast is inverted.
  task automatic do_fetch(input bit rl, input int w, input bit pat, input int row_base,
                          input bit bubbles, input int abuse_idx, input int bad_last_idx);
    int  nrows, start_acc, start_fd, n;
    bit  full;
    full  = rl || !primed_m;
    nrows = full ? w + 2 : 1;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < SRC_W; c++) begin
        if (pat) burst[r][c] = {3{8'(16 * (row_base + r) + c)}};
        else     burst[r][c] = 24'($urandom);
      end
    end
    start_acc = acc_cnt;
    start_fd  = fd_cnt;
    raise_request(rl, full ? w : int'($urandom_range(1, 5)));
    chk("req_tready", int'(s_axis_tready), 1);
    chk("req_window_valid", int'(window_valid), 0);
    n = 0;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < SRC_W; c++) begin
        if (n == abuse_idx) begin
          in_stream_ready = 1'b0;
          tick();
          row_to_wait     = WAIT_W'(1);
          reload          = 1'b1;
          in_stream_ready = 1'b1;
        end
        send_beat(burst[r][c], (c == SRC_W - 1) ^ (n == bad_last_idx),
                  bubbles && ($urandom_range(0, 1) == 1));
        n++;
      end
    end
    chk("fetch_done_pulse", int'(fetch_done), 1);
    // Extra offered beats after the window is complete must not be taken.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = $urandom;
    tick();
    chk("fetch_done_one_cycle", int'(fetch_done), 0);
    chk("window_valid", int'(window_valid), 1);
    chk("tready_after_done", int'(s_axis_tready), 0);
    tick();
    s_axis_tvalid = 1'b0;
    tick();
    chk("beats_accepted", acc_cnt - start_acc, nrows * SRC_W);
    chk("fetch_done_count", fd_cnt - start_fd, 1);
    for (int c = 0; c < SRC_W; c++) begin
      if (full) begin
        top_m[c] = to565(burst[w][c]);
        bot_m[c] = to565(burst[w + 1][c]);
      end else begin
        top_m[c] = bot_m[c];
        bot_m[c] = to565(burst[0][c]);
      end
    end
    primed_m = 1'b1;
    if (bad_last_idx >= 0 && TLAST_EN) err_m = 1'b1;
    chk("err", int'(err), int'(err_m));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " n0"}, int'(neighbor0), 0);
    chk({tag, " n1"}, int'(neighbor1), 0);
    chk({tag, " n2"}, int'(neighbor2), 0);
    chk({tag, " n3"}, int'(neighbor3), 0);
    chk({tag, " fetch_done"}, int'(fetch_done), 0);
    chk({tag, " window_valid"}, int'(window_valid), 0);
    chk({tag, " tready"}, int'(s_axis_tready), 0);
    chk({tag, " err"}, int'(err), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_n         = 1'b0;
    s_axis_tdata    = '0;
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    in_stream_ready = 1'b0;
    reload          = 1'b0;
    row_to_wait     = '0;
    neighbor_offset = '0;
    model_clear();

    vt[0] = '{ofs: 11'd2,     c0: 2, c1: 3};
    vt[1] = '{ofs: 11'd0,     c0: 0, c1: 1};
    vt[2] = '{ofs: 11'd6,     c0: 6, c1: 7};
    vt[3] = '{ofs: 11'd7,     c0: 7, c1: 7};
    vt[4] = '{ofs: 11'd20,    c0: 7, c1: 7};
    vt[5] = '{ofs: 11'h7FF,   c0: 0, c1: 1};
    vt[6] = '{ofs: 11'h400,   c0: 0, c1: 1};
    vt[7] = '{ofs: 11'h3FF,   c0: 7, c1: 7};
    vt[8] = '{ofs: 11'd5,     c0: 5, c1: 6};

    tick();
    tick();
    tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Prime with patterned rows 0 and 1, then the clamp table.
    do_fetch(1'b1, 0, 1'b1, 0, 1'b0, -1, -1);
    for (int i = 0; i < 9; i++) chk_cols(vt[i].ofs, vt[i].c0, vt[i].c1);

    // Advance with row 2.
    do_fetch(1'b0, 0, 1'b1, 2, 1'b0, -1, -1);
    chk_ofs(11'd2);
    chk_ofs(11'd7);

    // Reload skipping three rows: window is rows 3 and 4 of the burst.
    do_fetch(1'b1, 3, 1'b1, 0, 1'b0, -1, -1);
    for (int i = 0; i < 9; i++) chk_cols(vt[i].ofs, vt[i].c0, vt[i].c1);

    // tvalid bubbles.
    do_fetch(1'b1, 1, 1'b0, 0, 1'b1, -1, -1);
    chk_ofs(11'd3);

    // Spurious request edge during LOAD_TOP (skip one row, abuse at beat 10).
    do_fetch(1'b1, 1, 1'b0, 0, 1'b0, SRC_W + 2, -1);
    chk_ofs(11'd1);
    chk_ofs(11'd6);

    // Randomized fetches.
    for (int it = 0; it < 12; it++) begin
      do_fetch(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 0,
               1'($urandom_range(0, 1)), -1, -1);
      chk_ofs(OFS_W'($urandom_range(0, 2047)));
      chk_ofs(OFS_W'($urandom_range(0, 9)));
    end

    // tlast on beat 5 of the top row; err is sticky across the next fetch.
    do_fetch(1'b1, 0, 1'b0, 0, 1'b0, -1, 5);
    chk_ofs(11'd4);
    do_fetch(1'b0, 0, 1'b0, 0, 1'b0, -1, -1);

    // Reset in the middle of LOAD_BOT.
    raise_request(1'b1, 0);
    for (int i = 0; i < SRC_W + 3; i++) begin
      send_beat(24'($urandom), i == SRC_W - 1, 1'b0);
    end
    reset_n         = 1'b0;
    in_stream_ready = 1'b0;
    tick();
    chk_all_zero("midfetch_reset");
    tick();
    reset_n = 1'b1;
    model_clear();
    tick();
    chk_ofs(11'd3);

    // Unprimed advance request behaves as a reload.
    do_fetch(1'b0, 1, 1'b0, 0, 1'b1, -1, -1);
    chk_ofs(11'd0);
    chk_ofs(11'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
